// File: rtl/rec_approx_mult_pipe.sv
// Pipelined WIDTH x WIDTH unsigned recursive multiplier built from 2x2 leaves,
// each leaf exact or approximate depending on the per-beat accuracy mode.
module rec_approx_mult_pipe #(
    parameter int WIDTH    = 8,
    parameter int K_APPROX = 2,
    parameter int TAG_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Y,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int D      = WIDTH / 2;
    // Level r holds (D>>r)^2 partial products of (4<<r) bits = WIDTH^2 >> r bits,
    // so all levels pack back to back into one bus; level r starts at OFF(r).
    localparam int TOT    = 2*WIDTH*WIDTH - ((2*WIDTH*WIDTH) >> LEVELS);
    localparam int Y_OFF  = TOT - 2*WIDTH;

    logic [TOT-1:0]    pipe_q;
    logic [TOT-1:0]    pipe_d;
    logic [LEVELS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q [LEVELS];
    logic              adv;

    assign out_valid = valid_q[LEVELS-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign Y         = pipe_q[Y_OFF +: 2*WIDTH];
    assign out_tag   = tag_q[LEVELS-1];

    genvar gi, gj, gr, bi, bj;
    generate
        for (gi = 0; gi < D; gi++) begin : g_row
            for (gj = 0; gj < D; gj++) begin : g_leaf
                localparam bit LOW = (gi + gj) < K_APPROX;
                logic [1:0] x;
                logic [1:0] y;
                logic       p01;
                logic       p10;
                logic       p11;
                logic       approx;
                logic [3:0] leaf;

                assign x      = a[2*gi +: 2];
                assign y      = b[2*gj +: 2];
                assign p01    = x[0] & y[1];
                assign p10    = x[1] & y[0];
                assign p11    = x[1] & y[1];
                assign approx = (mode == 2'b01) || ((mode == 2'b10) && LOW);
                assign leaf   = approx ? {p01 & p10, (p01 & p10) ^ p11, p01 ^ p10, p01 & p10}
                                       : {2'b00, x} * {2'b00, y};
                assign pipe_d[(gi*D + gj)*4 +: 4] = leaf;
            end
        end

        for (gr = 1; gr < LEVELS; gr++) begin : g_lvl
            localparam int NB   = D >> gr;
            localparam int PW   = 4 << gr;
            localparam int H    = 1 << gr;
            localparam int PPW  = PW / 2;
            localparam int PNB  = 2 * NB;
            localparam int OFF  = 2*WIDTH*WIDTH - ((2*WIDTH*WIDTH) >> gr);
            localparam int POFF = 2*WIDTH*WIDTH - ((2*WIDTH*WIDTH) >> (gr - 1));
            for (bi = 0; bi < NB; bi++) begin : g_row
                for (bj = 0; bj < NB; bj++) begin : g_blk
                    logic [PW-1:0] ll;
                    logic [PW-1:0] hl;
                    logic [PW-1:0] lh;
                    logic [PW-1:0] hh;

                    // hl: high half of a times low half of b
                    assign ll = {{PPW{1'b0}}, pipe_q[POFF + ((2*bi)*PNB + 2*bj)*PPW +: PPW]};
                    assign hl = {{PPW{1'b0}}, pipe_q[POFF + ((2*bi+1)*PNB + 2*bj)*PPW +: PPW]};
                    assign lh = {{PPW{1'b0}}, pipe_q[POFF + ((2*bi)*PNB + 2*bj+1)*PPW +: PPW]};
                    assign hh = {{PPW{1'b0}}, pipe_q[POFF + ((2*bi+1)*PNB + 2*bj+1)*PPW +: PPW]};
                    assign pipe_d[OFF + (bi*NB + bj)*PW +: PW] =
                        ll + (hl << H) + (lh << H) + (hh << (2*H));
                end
            end
        end
    endgenerate

    // Whole pipeline advances together; bubbles are held, never squeezed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q  <= '0;
            valid_q <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                tag_q[l] <= '0;
            end
        end else if (adv) begin
            pipe_q   <= pipe_d;
            valid_q  <= {valid_q[LEVELS-2:0], in_valid};
            tag_q[0] <= in_tag;
            for (int l = 1; l < LEVELS; l++) begin
                tag_q[l] <= tag_q[l-1];
            end
        end
    end

endmodule

// File: doc/rec_approx_mult_pipe.md
Name: rec_approx_mult_pipe

Overview:
- Parametrised, pipelined N×N unsigned recursive multiplier with valid/ready handshake.
- Successor to the team's fixed 4×4 combinational recursive multiplier built from 2×2 approximate leaves.
- Adds generic power-of-two width, one register stage per recursion level, and a per-transaction accuracy mode (exact, fully approximate, or low-significance-only approximate).
- Sits as a drop-in multiplier for datapath/DSP blocks where error-versus-power is traded at run time.

Parameters:
- WIDTH, 8, operand width; power of two, ≥4.
- K_APPROX, 2, mode 2'b10 only: leaf (i,j) is approximate iff i+j < K_APPROX.
- TAG_W, 4, width of the sideband tag carried with each operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- mode  in  2  accuracy mode for this beat: 00 exact, 01 all leaves approximate, 10 low-order leaves approximate, 11 treated as 00.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- Y  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the beat in Y.

Behaviour:
- Leaf decomposition:
  - Operands split into 2-bit digits a_i, b_j, i,j = 0..WIDTH/2-1.
  - Leaf (i,j) has weight 2^(2(i+j)).
- Exact leaf: a_i*b_j.
- Approximate leaf, with p01 = x0&y1, p10 = x1&y0, p11 = x1&y1:
  - bit0 = p01&p10
  - bit1 = p01^p10
  - bit2 = (p01&p10)^p11
  - bit3 = p01&p10
- Mode is sampled with the operands and travels with the beat; changing mode never affects beats already in flight.
- Pipeline:
  - Stage 0 registers all leaf products, the tag and a valid bit.
  - Recursion levels r = 1..log2(WIDTH)-1 each register one combine step: P = LL + (HL<<h) + (LH<<h) + (HH<<2h), where h is half the sub-operand width at that level.
  - Sums are computed at full width with no truncation.
  - Latency = log2(WIDTH) cycles from accepted beat to out_valid (WIDTH=8 → 3, WIDTH=4 → 2).
  - Throughput is 1 beat/cycle.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - The beat is accepted when in_valid & in_ready.
  - When adv = 0 the whole pipeline (data, tags, valids) holds; bubbles are not squeezed.
  - Y and out_tag stay stable while out_valid & !out_ready.
  - Simultaneous accept and output handoff in the same cycle is legal; no beat is lost or duplicated.
- Ordering: results leave in acceptance order; out_tag identifies each beat.
- Reset (any time, including mid-operation):
  - All valid bits, Y, out_tag and internal registers are cleared to 0 asynchronously.
  - out_valid = 0 and in_ready = 1 on the first cycle after release.
  - In-flight beats are discarded.
- Boundary cases:
  - Zero operand → Y = 0 in every mode.
  - All-ones operands in approximate modes give the exact result, since 3×3 leaves are exact.
  - K_APPROX = 0 makes mode 10 equal to exact.
  - K_APPROX ≥ WIDTH-1 makes mode 10 equal to mode 01.

Test Plan:
- WIDTH=8, mode 00, a=200, b=150, tag=5 → Y=30000, out_tag=5, exactly 3 cycles after acceptance.
- WIDTH=8, mode 01, a=1, b=1 → Y=0; a=3, b=1 → Y=2; a=255, b=255 → Y=65025.
- WIDTH=8, mode 10, K_APPROX=1, a=0x11, b=0x01:
  - leaf (0,0) approximate (1×1 → 0); leaf (2,0) exact.
  - Y=16 (exact result 17).
- Back-to-back beats with modes 00/01/00 on a=b=1 (tags 1,2,3), out_ready held 0 for 4 cycles then 1:
  - Results 1, 0, 1 in tag order.
  - in_ready low while stalled; Y and out_tag stable throughout the stall.
- Random a, b, mode for 10k beats with random in_valid/out_ready → every result matches the reference model in order; no drops or duplicates.
- rst_n asserted for 1 cycle with 2 beats in flight → out_valid = 0 and Y = 0 immediately; no stale result appears after release.
